dp_ram_param: RTL and testbench

//  Parametrised simple dual-port RAM: one write port, one read port, single clock.

---
 rtl/dp_ram_param.sv | 150 +++++++++++++++
 tb/tb_dp_ram_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_param.sv
// Simple dual-port RAM: one write port, one read port, one clock.
// Read latency and read-during-write policy are selectable; a clear sequencer zeroes the array after reset.
module dp_ram_param #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              read_oob,
  output logic              init_busy
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                init_busy_q, init_busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [IDX_W-1:0]    mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  logic                rd_vld_c, rd_oob_c;
  logic [DATA_W-1:0]   rd_word_c;

  logic                vld_p0_q, vld_p0_d;
  logic                oob_p0_q, oob_p0_d;
  logic [DATA_W-1:0]   data_p0_q, data_p0_d;

  logic                s_vld, s_oob;
  logic [DATA_W-1:0]   s_data;

  logic                read_valid_q, read_valid_d;
  logic                read_oob_q, read_oob_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_wa    = to_idx(write_addr);
    mem_wd    = write_data;
    rd_vld_c  = 1'b0;
    rd_oob_c  = 1'b0;
    rd_word_c = '0;
    case (state_q)
      S_CLEAR: begin
        if (INIT_CLEAR != 0) begin
          mem_we = 1'b1;
          mem_wa = to_idx(ptr_q);
          mem_wd = '0;
          ptr_d  = ptr_q + 1'b1;
          if (ptr_q == LAST_A) state_d = S_READY;
        end else begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        mem_we   = write_en && in_range(write_addr);
        rd_vld_c = read_en;
        rd_oob_c = !in_range(read_addr);
        if (in_range(read_addr)) begin
          // Array read sees pre-edge contents, so old data is the natural result without bypass.
          if ((BYPASS != 0) && mem_we && (write_addr == read_addr))
            rd_word_c = write_data;
          else
            rd_word_c = mem_q[to_idx(read_addr)];
        end
      end
      default: state_d = S_CLEAR;
    endcase
    init_busy_d = (state_d == S_CLEAR);

    // Stage p0: optional extra register for RD_LATENCY=2
    vld_p0_d  = rd_vld_c;
    oob_p0_d  = rd_oob_c;
    data_p0_d = rd_word_c;
    if (RD_LATENCY == 2) begin
      s_vld  = vld_p0_q;
      s_oob  = oob_p0_q;
      s_data = data_p0_q;
    end else begin
      s_vld  = rd_vld_c;
      s_oob  = rd_oob_c;
      s_data = rd_word_c;
    end

    // Output stage: data held between valid pulses
    read_valid_d = s_vld;
    read_oob_d   = s_vld && s_oob;
    read_data_d  = s_vld ? s_data : read_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      ptr_q        <= '0;
      init_busy_q  <= 1'b1;
      vld_p0_q     <= 1'b0;
      oob_p0_q     <= 1'b0;
      read_valid_q <= 1'b0;
      read_oob_q   <= 1'b0;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      init_busy_q  <= init_busy_d;
      vld_p0_q     <= vld_p0_d;
      oob_p0_q     <= oob_p0_d;
      read_valid_q <= read_valid_d;
      read_oob_q   <= read_oob_d;
      read_data_q  <= read_data_d;
    end
  end

  always_ff @(posedge clk) begin
    data_p0_q <= data_p0_d;
    if (mem_we && !rst) mem_q[mem_wa] <= mem_wd;
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign read_oob   = read_oob_q;
  assign init_busy  = init_busy_q;

endmodule

// File: tb/tb_dp_ram_param.sv
// Directed bench for dp_ram_param: two instances (latency 1 + bypass, latency 2 + old-data)
// share the same stimulus and are checked against hand-computed vector tables.
module tb_dp_ram_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en, read_en;
  logic [7:0] write_addr, read_addr;
  logic [3:0] write_data;

  logic [3:0] rd_data_a, rd_data_b;
  logic       rd_vld_a, rd_vld_b, rd_oob_a, rd_oob_b, busy_a, busy_b;

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] last_a = 4'h0;
  logic [3:0] last_b = 4'h0;

  typedef struct {
    logic       we;
    logic [7:0] wa;
    logic [3:0] wd;
    logic       re;
    logic [7:0] ra;
    logic [3:0] ea;   // expected data, BYPASS=1 instance
    logic [3:0] eb;   // expected data, BYPASS=0 instance
    logic       eoob;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  dp_ram_param #(.DATA_W(4), .ADDR_W(8), .DEPTH(200), .RD_LATENCY(1), .BYPASS(1), .INIT_CLEAR(1)) u_a (
    .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(rd_data_a), .read_valid(rd_vld_a),
    .read_oob(rd_oob_a), .init_busy(busy_a));

  dp_ram_param #(.DATA_W(4), .ADDR_W(8), .DEPTH(200), .RD_LATENCY(2), .BYPASS(0), .INIT_CLEAR(1)) u_b (
    .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(rd_data_b), .read_valid(rd_vld_b),
    .read_oob(rd_oob_b), .init_busy(busy_b));

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] wa, input logic [3:0] wd,
                              input logic re, input logic [7:0] ra, input logic [3:0] ea,
                              input logic [3:0] eb, input logic eoob);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.ea = ea; v.eb = eb; v.eoob = eoob;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [7:0] wa, input logic [3:0] wd,
                       input logic re, input logic [7:0] ra);
    write_en = we; write_addr = wa; write_data = wd; read_en = re; read_addr = ra;
  endtask

  task automatic check_rd(input string nm, input logic v, input logic [3:0] d, input logic o,
                          input logic re, input logic [3:0] e, input logic eo,
                          inout logic [3:0] last);
    chk({nm, " valid"}, int'(v), int'(re));
    if (re) begin
      chk({nm, " data"}, int'(d), int'(e));
      chk({nm, " oob"}, int'(o), int'(eo));
      last = e;
    end else begin
      chk({nm, " oob idle"}, int'(o), 0);
      chk({nm, " data hold"}, int'(d), int'(last));
    end
  endtask

  // Vector k is driven on negedge k; instance a answers one negedge later, instance b two.
  task automatic run_vectors(input string tag);
    int nv;
    nv = vt.size();
    for (int c = 0; c < nv + 2; c++) begin
      @(negedge clk);
      if (c >= 1) check_rd($sformatf("%s a v%0d", tag, c - 1), rd_vld_a, rd_data_a, rd_oob_a,
                           vt[c-1].re, vt[c-1].ea, vt[c-1].eoob, last_a);
      if (c >= 2) check_rd($sformatf("%s b v%0d", tag, c - 2), rd_vld_b, rd_data_b, rd_oob_b,
                           vt[c-2].re, vt[c-2].eb, vt[c-2].eoob, last_b);
      if (c < nv) drive(vt[c].we, vt[c].wa, vt[c].wd, vt[c].re, vt[c].ra);
      else        drive(1'b0, 8'h00, 4'h0, 1'b0, 8'h00);
    end
  endtask

  // Releases reset at the current negedge, pokes the ports during clear, counts busy cycles.
  task automatic clear_phase(input string tag);
    int cnt, vseen_a, vseen_b;
    cnt = 0; vseen_a = 0; vseen_b = 0;
    rst = 1'b0;
    drive(1'b1, 8'h05, 4'hF, 1'b1, 8'h05);
    while (busy_a && cnt < 1000) begin
      cnt++;
      @(negedge clk);
      if (rd_vld_a) vseen_a++;
      if (rd_vld_b) vseen_b++;
    end
    drive(1'b0, 8'h00, 4'h0, 1'b0, 8'h00);
    chk({tag, " busy cycles"}, cnt, 200);
    chk({tag, " busy a done"}, int'(busy_a), 0);
    chk({tag, " busy b done"}, int'(busy_b), 0);
    chk({tag, " no valid during clear a"}, vseen_a, 0);
    chk({tag, " no valid during clear b"}, vseen_b, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 4'h0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("reset busy a", int'(busy_a), 1);
    chk("reset busy b", int'(busy_b), 1);
    chk("reset valid a", int'(rd_vld_a), 0);
    chk("reset valid b", int'(rd_vld_b), 0);
    chk("reset data a", int'(rd_data_a), 0);
    chk("reset oob b", int'(rd_oob_b), 0);

    clear_phase("init");

    //              we   wa     wd    re   ra     ea    eb    oob
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h63, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'hC7, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h05, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b1, 8'h00, 4'hA, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b1, 8'h01, 4'hC, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b1, 8'h0A, 4'h3, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 4'hA, 4'hA, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h0A, 4'h3, 4'h3, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h01, 4'hC, 4'hC, 1'b0));
    vt.push_back(mk(1'b1, 8'hFF, 4'h5, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'hFF, 4'h0, 4'h0, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'hC7, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b1, 8'h10, 4'h6, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b1, 8'h10, 4'h9, 1'b1, 8'h10, 4'h9, 4'h6, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h10, 4'h9, 4'h9, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b1, 8'h20, 4'h7, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h20, 4'h7, 4'h7, 1'b0));
    vt.push_back(mk(1'b1, 8'hC7, 4'hE, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'hC7, 4'hE, 4'hE, 1'b0));
    vt.push_back(mk(1'b1, 8'hC8, 4'h1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'hC8, 4'h0, 4'h0, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h08, 4'h0, 4'h0, 1'b0));
    run_vectors("main");

    // Mid-read reset: read in cycle N, reset in N+1; the latency-2 read must never appear.
    @(negedge clk);
    drive(1'b0, 8'h00, 4'h0, 1'b1, 8'h00);
    @(negedge clk);
    chk("midrst a valid", int'(rd_vld_a), 1);
    chk("midrst a data", int'(rd_data_a), 4'hA);
    chk("midrst b not yet", int'(rd_vld_b), 0);
    drive(1'b0, 8'h00, 4'h0, 1'b0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst b flushed", int'(rd_vld_b), 0);
    chk("midrst busy a", int'(busy_a), 1);
    chk("midrst busy b", int'(busy_b), 1);
    chk("midrst data a reset", int'(rd_data_a), 0);
    @(negedge clk);
    chk("midrst b still none", int'(rd_vld_b), 0);
    last_a = 4'h0;
    last_b = 4'h0;
    clear_phase("restart");

    vt.delete();
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h10, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'hC7, 4'h0, 4'h0, 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 4'h0, 1'b1, 8'h05, 4'h0, 4'h0, 1'b0));
    run_vectors("post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
